// File: rtl/cmp_search_ctrl_pkg.sv
// Shared types for the successive-approximation comparator search controller.
// Holds the FSM state encoding and the width helper for the probe counter.
package cmp_search_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StProbe = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Probe count never exceeds width+1, so this many bits always suffice.
  function automatic int unsigned probes_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/cmp_search_ctrl.sv
// Binary-search controller: drives guesses into an external magnitude comparator
// and recovers the hidden operand from its gt/eq/lt flags.
module cmp_search_ctrl
  import cmp_search_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CMP_LAT = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                cmp_gt,
  input  logic                                cmp_eq,
  input  logic                                cmp_lt,
  output logic [WIDTH-1:0]                    guess,
  output logic                                busy,
  output logic                                done,
  output logic                                found,
  output logic                                err,
  output logic [WIDTH-1:0]                    result,
  output logic [probes_width(WIDTH)-1:0]      probes
);

  localparam int unsigned    PW       = probes_width(WIDTH);
  localparam int unsigned    WaitW    = (CMP_LAT != 0) ? $clog2(CMP_LAT + 1) : 1;
  localparam logic [WIDTH:0] RangeMax = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ExtOne   = (WIDTH + 1)'(1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  guess_q, guess_d, result_q, result_d;
  logic [WIDTH:0]    lo_q, lo_d, hi_q, hi_d, guess_ext;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [PW-1:0]     probes_q, probes_d;
  logic              found_q, found_d, err_q, err_d;
  logic              sample, finish;

  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] a,
                                                 input logic [WIDTH:0] b);
    logic [WIDTH:0] sum;
    sum = a + b;
    return sum[WIDTH:1];
  endfunction

  assign guess_ext = {1'b0, guess_q};
  assign sample    = (state_q == StProbe) && (wait_q == WaitW'(CMP_LAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StProbe;
      StProbe: if (finish) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    guess_d  = guess_q;
    result_d = result_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    wait_d   = wait_q;
    probes_d = probes_q;
    found_d  = found_q;
    err_d    = err_q;
    finish   = 1'b0;
    if (state_q == StIdle && start) begin
      lo_d     = '0;
      hi_d     = RangeMax;
      guess_d  = midpoint('0, RangeMax);
      wait_d   = '0;
      probes_d = '0;
      found_d  = 1'b0;
      err_d    = 1'b0;
    end else if (state_q == StProbe) begin
      if (!sample) begin
        wait_d = wait_q + WaitW'(1);
      end else begin
        probes_d = probes_q + PW'(1);
        finish   = 1'b1;
        case ({cmp_gt, cmp_eq, cmp_lt})
          3'b010: begin
            result_d = guess_q;
            found_d  = 1'b1;
          end
          3'b100: begin
            lo_d = guess_ext + ExtOne;
            // guess >= hi means the raised lo would pass hi
            if (guess_ext >= hi_q) begin
              err_d = 1'b1;
            end else begin
              guess_d = midpoint(lo_d, hi_q);
              wait_d  = '0;
              finish  = 1'b0;
            end
          end
          3'b001: begin
            hi_d = guess_ext - ExtOne;
            if (guess_ext <= lo_q) begin
              err_d = 1'b1;
            end else begin
              guess_d = midpoint(lo_q, hi_d);
              wait_d  = '0;
              finish  = 1'b0;
            end
          end
          default: begin
            err_d   = 1'b1;
            found_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guess_q  <= '0;
      result_q <= '0;
      lo_q     <= '0;
      hi_q     <= RangeMax;
      wait_q   <= '0;
      probes_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      guess_q  <= guess_d;
      result_q <= result_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      wait_q   <= wait_d;
      probes_q <= probes_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    busy = (state_q == StProbe);
    done = (state_q == StDone);
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign probes = probes_q;
  assign found  = found_q;
  assign err    = err_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Bench for cmp_search_ctrl: three instances (4-bit comb, 4-bit with latency 2,
// 2-bit) against behavioural comparators and an integer binary-search model.
module tb_cmp_search_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 0: WIDTH=4, CMP_LAT=0
  int          a0 = 0;
  bit          bad0 = 1'b0;
  logic        start0 = 1'b0;
  logic        gt0, eq0, lt0, busy0, done0, found0, err0;
  logic [3:0]  guess0, result0;
  logic [2:0]  probes0;
  assign gt0 = bad0 ? 1'b1 : (a0 > int'(guess0));
  assign eq0 = bad0 ? 1'b0 : (a0 == int'(guess0));
  assign lt0 = bad0 ? 1'b1 : (a0 < int'(guess0));

  cmp_search_ctrl #(.WIDTH(4), .CMP_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cmp_gt(gt0), .cmp_eq(eq0), .cmp_lt(lt0),
    .guess(guess0), .busy(busy0), .done(done0), .found(found0), .err(err0),
    .result(result0), .probes(probes0)
  );

  // Instance 1: WIDTH=4, CMP_LAT=2
  int          a1 = 0;
  logic        start1 = 1'b0;
  logic        gt1, eq1, lt1, busy1, done1, found1, err1;
  logic [3:0]  guess1, result1;
  logic [2:0]  probes1;
  assign gt1 = a1 > int'(guess1);
  assign eq1 = a1 == int'(guess1);
  assign lt1 = a1 < int'(guess1);

  cmp_search_ctrl #(.WIDTH(4), .CMP_LAT(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmp_gt(gt1), .cmp_eq(eq1), .cmp_lt(lt1),
    .guess(guess1), .busy(busy1), .done(done1), .found(found1), .err(err1),
    .result(result1), .probes(probes1)
  );

  // Instance 2: WIDTH=2, CMP_LAT=0
  int          a2 = 0;
  logic        start2 = 1'b0;
  logic        gt2, eq2, lt2, busy2, done2, found2, err2;
  logic [1:0]  guess2, result2;
  logic [1:0]  probes2;
  assign gt2 = a2 > int'(guess2);
  assign eq2 = a2 == int'(guess2);
  assign lt2 = a2 < int'(guess2);

  cmp_search_ctrl #(.WIDTH(2), .CMP_LAT(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cmp_gt(gt2), .cmp_eq(eq2), .cmp_lt(lt2),
    .guess(guess2), .busy(busy2), .done(done2), .found(found2), .err(err2),
    .result(result2), .probes(probes2)
  );

  // Reference model results
  int exp_seq[$];
  bit exp_found;
  int exp_probes;

  // Observations from the last search
  int trace[$];
  int done_edge, first_busy, fin_busy, fin_found, fin_err, fin_result, fin_probes, done_after;

  function automatic void model_search(input int a, input int w);
    int lo = 0;
    int hi = (1 << w) - 1;
    int g;
    exp_seq.delete();
    exp_found = 1'b0;
    while (lo <= hi) begin
      g = (lo + hi) / 2;
      exp_seq.push_back(g);
      if (g == a) begin
        exp_found = 1'b1;
        break;
      end
      if (a > g) lo = g + 1;
      else hi = g - 1;
    end
    exp_probes = exp_seq.size();
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic set_a(input int which, input int v);
    case (which)
      0: a0 = v;
      1: a1 = v;
      default: a2 = v;
    endcase
  endtask

  task automatic snapshot(input int which, output int g, output int d, output int b,
                          output int f, output int e, output int r, output int p);
    case (which)
      0: begin g = guess0; d = done0; b = busy0; f = found0; e = err0; r = result0; p = probes0; end
      1: begin g = guess1; d = done1; b = busy1; f = found1; e = err1; r = result1; p = probes1; end
      default: begin
        g = guess2; d = done2; b = busy2; f = found2; e = err2; r = result2; p = probes2;
      end
    endcase
  endtask

  // Pulses start, records the guess after every edge until done; edge 0 accepts start.
  // restart_k >= 0 raises start again during the search as a stray pulse.
  task automatic drive_search(input int which, input int a, input int restart_k);
    int g, d, b, f, e, r, p;
    trace.delete();
    done_edge = -1;
    set_a(which, a);
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    #1;
    set_start(which, 1'b0);
    for (int k = 0; k < 60; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      snapshot(which, g, d, b, f, e, r, p);
      if (k == 0) first_busy = b;
      if (d != 0) begin
        done_edge = k;
        fin_busy = b; fin_found = f; fin_err = e; fin_result = r; fin_probes = p;
        break;
      end
      trace.push_back(g);
      if (k == restart_k) set_start(which, 1'b1);
      else if (k == restart_k + 1) set_start(which, 1'b0);
    end
    set_start(which, 1'b0);
    @(posedge clk);
    #1;
    snapshot(which, g, d, b, f, e, r, p);
    done_after = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({guess0, busy0, done0, found0, err0, result0, probes0} !== '0) begin
      errors++;
      $display("FAIL reset_dut0: got %h, expected 0",
               {guess0, busy0, done0, found0, err0, result0, probes0});
    end
    checks++;
    if ({guess1, busy1, done1, guess2, busy2, done2} !== '0) begin
      errors++;
      $display("FAIL reset_others: got %h, expected 0", {guess1, busy1, done1, guess2, busy2, done2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed;
    int vals[3] = '{7, 0, 15};
    foreach (vals[n]) begin
      model_search(vals[n], 4);
      drive_search(0, vals[n], -1);
      checks++;
      if (first_busy != 1) begin
        errors++;
        $display("FAIL dir_busy A=%0d: got %0d, expected 1", vals[n], first_busy);
      end
      checks++;
      if (trace.size() != exp_seq.size()) begin
        errors++;
        $display("FAIL dir_seq_len A=%0d: got %0d, expected %0d", vals[n], trace.size(),
                 exp_seq.size());
      end else begin
        foreach (exp_seq[i]) begin
          checks++;
          if (trace[i] != exp_seq[i]) begin
            errors++;
            $display("FAIL dir_guess A=%0d step %0d: got %0d, expected %0d", vals[n], i,
                     trace[i], exp_seq[i]);
          end
        end
      end
      checks++;
      if (done_edge != exp_probes) begin
        errors++;
        $display("FAIL dir_done_edge A=%0d: got %0d, expected %0d", vals[n], done_edge, exp_probes);
      end
      checks++;
      if (fin_result != vals[n] || fin_probes != exp_probes || fin_found != 1 || fin_err != 0) begin
        errors++;
        $display("FAIL dir_outputs A=%0d: got result=%0d probes=%0d found=%0d err=%0d, expected %0d %0d 1 0",
                 vals[n], fin_result, fin_probes, fin_found, fin_err, vals[n], exp_probes);
      end
      checks++;
      if (fin_busy != 0 || done_after != 0) begin
        errors++;
        $display("FAIL dir_done_pulse A=%0d: got busy=%0d done_next=%0d, expected 0 0",
                 vals[n], fin_busy, done_after);
      end
    end
  endtask

  task automatic test_latency;
    int exp_tr[$];
    int vals[2];
    vals[0] = 9;
    vals[1] = int'($urandom_range(0, 15));
    foreach (vals[n]) begin
      model_search(vals[n], 4);
      exp_tr.delete();
      foreach (exp_seq[i]) repeat (3) exp_tr.push_back(exp_seq[i]);
      drive_search(1, vals[n], -1);
      checks++;
      if (trace.size() != exp_tr.size()) begin
        errors++;
        $display("FAIL lat_trace_len A=%0d: got %0d, expected %0d", vals[n], trace.size(),
                 exp_tr.size());
      end else begin
        foreach (exp_tr[i]) begin
          checks++;
          if (trace[i] != exp_tr[i]) begin
            errors++;
            $display("FAIL lat_guess A=%0d cycle %0d: got %0d, expected %0d", vals[n], i,
                     trace[i], exp_tr[i]);
          end
        end
      end
      checks++;
      if (done_edge != exp_probes * 3) begin
        errors++;
        $display("FAIL lat_done_edge A=%0d: got %0d, expected %0d", vals[n], done_edge,
                 exp_probes * 3);
      end
      checks++;
      if (fin_result != vals[n] || fin_found != 1 || fin_probes != exp_probes) begin
        errors++;
        $display("FAIL lat_outputs A=%0d: got result=%0d found=%0d probes=%0d, expected %0d 1 %0d",
                 vals[n], fin_result, fin_found, fin_probes, vals[n], exp_probes);
      end
    end
  endtask

  task automatic test_bad_flags;
    bad0 = 1'b1;
    drive_search(0, 3, -1);
    bad0 = 1'b0;
    checks++;
    if (done_edge != 1) begin
      errors++;
      $display("FAIL bad_done_edge: got %0d, expected 1", done_edge);
    end
    checks++;
    if (fin_err != 1 || fin_found != 0 || fin_probes != 1) begin
      errors++;
      $display("FAIL bad_outputs: got err=%0d found=%0d probes=%0d, expected 1 0 1",
               fin_err, fin_found, fin_probes);
    end
  endtask

  task automatic test_reset_mid;
    a0 = 12;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({guess0, busy0, done0, found0, err0, result0, probes0} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, expected 0",
               {guess0, busy0, done0, found0, err0, result0, probes0});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({guess0, busy0, done0} !== '0) begin
      errors++;
      $display("FAIL midreset_held: got %h, expected 0", {guess0, busy0, done0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_search(5, 4);
    drive_search(0, 5, -1);
    checks++;
    if (fin_result != 5 || fin_found != 1 || done_edge != exp_probes) begin
      errors++;
      $display("FAIL midreset_research: got result=%0d found=%0d edge=%0d, expected 5 1 %0d",
               fin_result, fin_found, done_edge, exp_probes);
    end
  endtask

  task automatic test_busy_ignore;
    model_search(13, 4);
    drive_search(0, 13, 1);
    checks++;
    if (trace != exp_seq) begin
      errors++;
      $display("FAIL busy_ignore_seq: got %p, expected %p", trace, exp_seq);
    end
    checks++;
    if (done_edge != exp_probes || fin_result != 13 || fin_probes != exp_probes) begin
      errors++;
      $display("FAIL busy_ignore_outputs: got edge=%0d result=%0d probes=%0d, expected %0d 13 %0d",
               done_edge, fin_result, fin_probes, exp_probes, exp_probes);
    end
  endtask

  task automatic test_random;
    int a;
    for (int n = 0; n < 16; n++) begin
      a = int'($urandom_range(0, 15));
      model_search(a, 4);
      drive_search(0, a, -1);
      checks++;
      if (trace != exp_seq || done_edge != exp_probes) begin
        errors++;
        $display("FAIL rand_seq A=%0d: got %p edge=%0d, expected %p edge=%0d",
                 a, trace, done_edge, exp_seq, exp_probes);
      end
      checks++;
      if (fin_result != a || fin_found != 1 || fin_err != 0 || fin_probes != exp_probes) begin
        errors++;
        $display("FAIL rand_outputs A=%0d: got result=%0d found=%0d err=%0d probes=%0d",
                 a, fin_result, fin_found, fin_err, fin_probes);
      end
    end
  endtask

  task automatic test_w2_sweep;
    for (int a = 0; a < 4; a++) begin
      model_search(a, 2);
      drive_search(2, a, -1);
      checks++;
      if (fin_result != a || fin_found != 1 || fin_probes > 3 || fin_probes != exp_probes) begin
        errors++;
        $display("FAIL w2_sweep A=%0d: got result=%0d found=%0d probes=%0d, expected %0d 1 %0d",
                 a, fin_result, fin_found, fin_probes, a, exp_probes);
      end
      checks++;
      if (done_edge != exp_probes) begin
        errors++;
        $display("FAIL w2_done_edge A=%0d: got %0d, expected %0d", a, done_edge, exp_probes);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_bad_flags();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    test_w2_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
